// File: rtl/pipeline_stall_controller_if.sv
// Hazard inputs and stage-register controls exchanged between the datapath
// and the stall controller.
interface pipeline_stall_controller_if #(
    parameter int REG_ADDR_W = 4,
    parameter int CNT_W      = 16
);
    logic                  id_ex_mem_read;
    logic [REG_ADDR_W-1:0] id_ex_rd;
    logic [REG_ADDR_W-1:0] if_id_rn;
    logic [REG_ADDR_W-1:0] if_id_rm;
    logic                  if_id_uses_rn;
    logic                  if_id_uses_rm;
    logic                  branch_taken;
    logic                  mem_req;
    logic                  mem_ready;

    logic                  pc_enable;
    logic                  if_id_enable;
    logic                  if_id_flush;
    logic                  id_ex_bubble;
    logic                  ex_mem_enable;
    logic                  mem_wb_bubble;
    logic                  mem_timeout;
    logic [CNT_W-1:0]      stall_cycles;

    modport master (
        output id_ex_mem_read, id_ex_rd, if_id_rn, if_id_rm,
               if_id_uses_rn, if_id_uses_rm, branch_taken, mem_req, mem_ready,
        input  pc_enable, if_id_enable, if_id_flush, id_ex_bubble,
               ex_mem_enable, mem_wb_bubble, mem_timeout, stall_cycles
    );

    modport slave (
        input  id_ex_mem_read, id_ex_rd, if_id_rn, if_id_rm,
               if_id_uses_rn, if_id_uses_rm, branch_taken, mem_req, mem_ready,
        output pc_enable, if_id_enable, if_id_flush, id_ex_bubble,
               ex_mem_enable, mem_wb_bubble, mem_timeout, stall_cycles
    );
endinterface

// File: rtl/pipeline_stall_controller.sv
// Hazard/stall sequencer for the 5-stage pipeline: load-use bubbles, branch
// flushes, memory-wait freeze with timeout into a sticky error state.
module pipeline_stall_controller #(
    parameter int REG_ADDR_W  = 4,
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    pipeline_stall_controller_if.slave   bus
);
    typedef enum logic [1:0] {ST_RUN, ST_MEM_WAIT, ST_ERROR} state_t;

    // R15 is the PC; it is never produced by a load into the register file
    localparam logic [REG_ADDR_W-1:0] PC_REG  = REG_ADDR_W'(15);
    localparam logic [7:0]            TIMEOUT = 8'(MEM_TIMEOUT);

    state_t           state_q, state_d;
    logic [7:0]       wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;

    logic load_use;
    logic mem_stall;
    logic pc_en;

    assign mem_stall = bus.mem_req & ~bus.mem_ready;
    assign load_use  = bus.id_ex_mem_read && (bus.id_ex_rd != PC_REG) &&
                       ((bus.if_id_uses_rn && (bus.if_id_rn == bus.id_ex_rd)) ||
                        (bus.if_id_uses_rm && (bus.if_id_rm == bus.id_ex_rd)));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= ST_RUN;
            wait_cnt_q     <= 8'd0;
            stall_cycles_q <= '0;
        end else begin
            state_q        <= state_d;
            wait_cnt_q     <= wait_cnt_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            ST_RUN: begin
                if (mem_stall) begin
                    state_d    = ST_MEM_WAIT;
                    wait_cnt_d = 8'd1;
                end
            end
            ST_MEM_WAIT: begin
                // a dropped request releases the freeze just like a ready
                if (!mem_stall) begin
                    state_d    = ST_RUN;
                    wait_cnt_d = 8'd0;
                end else if (wait_cnt_q == TIMEOUT) begin
                    state_d = ST_ERROR;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            default: state_d = ST_ERROR;
        endcase

        stall_cycles_d = stall_cycles_q;
        if (!pc_en && (stall_cycles_q != {CNT_W{1'b1}}))
            stall_cycles_d = stall_cycles_q + 1'b1;
    end

    always_comb begin
        pc_en             = 1'b1;
        bus.if_id_enable  = 1'b1;
        bus.ex_mem_enable = 1'b1;
        bus.if_id_flush   = 1'b0;
        bus.id_ex_bubble  = 1'b0;
        bus.mem_wb_bubble = 1'b0;
        bus.mem_timeout   = 1'b0;
        if (!reset) begin
            pc_en             = 1'b0;
            bus.if_id_enable  = 1'b0;
            bus.ex_mem_enable = 1'b0;
            bus.if_id_flush   = 1'b1;
            bus.id_ex_bubble  = 1'b1;
            bus.mem_wb_bubble = 1'b1;
        end else if (state_q == ST_ERROR) begin
            pc_en             = 1'b0;
            bus.if_id_enable  = 1'b0;
            bus.ex_mem_enable = 1'b0;
            bus.mem_timeout   = 1'b1;
        end else if (mem_stall) begin
            pc_en             = 1'b0;
            bus.if_id_enable  = 1'b0;
            bus.ex_mem_enable = 1'b0;
            bus.mem_wb_bubble = 1'b1;
        end else if (load_use) begin
            // load-use also masks a same-cycle branch flush
            pc_en             = 1'b0;
            bus.if_id_enable  = 1'b0;
            bus.id_ex_bubble  = 1'b1;
        end else if (bus.branch_taken) begin
            bus.if_id_flush   = 1'b1;
        end
    end

    assign bus.pc_enable    = pc_en;
    assign bus.stall_cycles = stall_cycles_q;
endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed bench: two controllers (default parameters and MEM_TIMEOUT=4/CNT_W=4)
// share stimulus; expectations are queued and checked by a negedge monitor.
module tb_pipeline_stall_controller;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pipeline_stall_controller_if #(.REG_ADDR_W(4), .CNT_W(16)) bus_a ();
    pipeline_stall_controller_if #(.REG_ADDR_W(4), .CNT_W(4))  bus_b ();

    pipeline_stall_controller #(.REG_ADDR_W(4), .MEM_TIMEOUT(16), .CNT_W(16)) dut_a (
        .clk(clk), .reset(rst_n), .bus(bus_a.slave));
    pipeline_stall_controller #(.REG_ADDR_W(4), .MEM_TIMEOUT(4), .CNT_W(4)) dut_b (
        .clk(clk), .reset(rst_n), .bus(bus_b.slave));

    // {pc_enable, if_id_enable, if_id_flush, id_ex_bubble, ex_mem_enable, mem_wb_bubble}
    localparam logic [5:0] NORM = 6'b110010;
    localparam logic [5:0] BR   = 6'b111010;
    localparam logic [5:0] LU   = 6'b000110;
    localparam logic [5:0] MS   = 6'b000001;
    localparam logic [5:0] RST  = 6'b001101;
    localparam logic [5:0] ERR  = 6'b000000;

    typedef struct {
        string      name;
        logic [5:0] ca;
        logic [5:0] cb;
        logic [15:0] na;
        logic [3:0] nb;
        logic       ta;
        logic       tb;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    wire [5:0] ctrl_a = {bus_a.pc_enable, bus_a.if_id_enable, bus_a.if_id_flush,
                         bus_a.id_ex_bubble, bus_a.ex_mem_enable, bus_a.mem_wb_bubble};
    wire [5:0] ctrl_b = {bus_b.pc_enable, bus_b.if_id_enable, bus_b.if_id_flush,
                         bus_b.id_ex_bubble, bus_b.ex_mem_enable, bus_b.mem_wb_bubble};

    task automatic chk(input string nm, input string f, input logic [15:0] act,
                       input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s %s: got %0h expected %0h", nm, f, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk(e.name, "ctrl_a", {10'd0, ctrl_a}, {10'd0, e.ca});
            chk(e.name, "ctrl_b", {10'd0, ctrl_b}, {10'd0, e.cb});
            chk(e.name, "cnt_a", bus_a.stall_cycles, e.na);
            chk(e.name, "cnt_b", {12'd0, bus_b.stall_cycles}, {12'd0, e.nb});
            chk(e.name, "tmo_a", {15'd0, bus_a.mem_timeout}, {15'd0, e.ta});
            chk(e.name, "tmo_b", {15'd0, bus_b.mem_timeout}, {15'd0, e.tb});
        end
    end

    task automatic drive(input logic rs, input logic mr, input logic [3:0] rd,
                         input logic [3:0] rn, input logic [3:0] rm, input logic urn,
                         input logic urm, input logic br, input logic req, input logic rdy);
        @(posedge clk);
        #1;
        rst_n = rs;
        bus_a.id_ex_mem_read = mr;  bus_b.id_ex_mem_read = mr;
        bus_a.id_ex_rd       = rd;  bus_b.id_ex_rd       = rd;
        bus_a.if_id_rn       = rn;  bus_b.if_id_rn       = rn;
        bus_a.if_id_rm       = rm;  bus_b.if_id_rm       = rm;
        bus_a.if_id_uses_rn  = urn; bus_b.if_id_uses_rn  = urn;
        bus_a.if_id_uses_rm  = urm; bus_b.if_id_uses_rm  = urm;
        bus_a.branch_taken   = br;  bus_b.branch_taken   = br;
        bus_a.mem_req        = req; bus_b.mem_req        = req;
        bus_a.mem_ready      = rdy; bus_b.mem_ready      = rdy;
    endtask

    task automatic expect2(input string nm, input logic [5:0] ca, input logic [5:0] cb,
                           input logic [15:0] na, input logic [3:0] nb,
                           input logic ta, input logic tb);
        exp_t e;
        e.name = nm; e.ca = ca; e.cb = cb; e.na = na; e.nb = nb; e.ta = ta; e.tb = tb;
        sb.push_back(e);
    endtask

    task automatic expect1(input string nm, input logic [5:0] c, input logic [15:0] n);
        expect2(nm, c, c, n, n[3:0], 1'b0, 1'b0);
    endtask

    task automatic quiet();
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); expect1("rst", RST, 0);
        quiet();                            expect1("rst_rel", NORM, 0);
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        expect1("rst0", RST, 0);
        for (int i = 0; i < 3; i++) begin
            drive(0, 1'($urandom_range(0, 1)), 4'($urandom), 4'($urandom), 4'($urandom),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)));
            expect1("rst_rand", RST, 0);
        end
        quiet(); expect1("rst_release", NORM, 0);

        // load-use and branch interactions
        drive(1, 1, 3, 3, 0, 1, 0, 0, 0, 0); expect1("lu_rn", LU, 0);
        quiet();                            expect1("lu_after", NORM, 1);
        drive(1, 1, 15, 15, 0, 1, 0, 0, 0, 0); expect1("lu_r15", NORM, 1);
        drive(1, 1, 3, 3, 0, 0, 0, 0, 0, 0);   expect1("lu_nouse", NORM, 1);
        drive(1, 1, 7, 0, 7, 0, 1, 0, 0, 0);   expect1("lu_rm", LU, 1);
        drive(1, 0, 3, 3, 0, 1, 0, 0, 0, 0);   expect1("lu_noload", NORM, 2);
        drive(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);   expect1("br_only", BR, 2);
        drive(1, 1, 3, 3, 0, 1, 0, 1, 0, 0);   expect1("br_lu", LU, 2);
        quiet();                               expect1("br_lu_after", NORM, 3);
        drive(1, 1, 5, 0, 5, 0, 1, 0, 0, 0);   expect1("lu_hold0", LU, 3);
        drive(1, 1, 5, 0, 5, 0, 1, 0, 0, 0);   expect1("lu_hold1", LU, 4);
        quiet();                               expect1("lu_hold_end", NORM, 5);

        // memory wait of 4 cycles; hits the MEM_TIMEOUT=4 boundary on dut_b
        do_reset();
        drive(1, 1, 3, 3, 0, 1, 0, 1, 1, 0);   expect1("mw_over_lu", MS, 0);
        for (int i = 1; i < 4; i++) begin
            drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 0); expect1("mw_stall", MS, 16'(i));
        end
        drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 1);   expect1("mw_ready", NORM, 4);
        quiet();                               expect1("mw_after", NORM, 4);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);   expect1("drop_s0", MS, 4);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);   expect1("drop_s1", MS, 5);
        drive(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);   expect1("drop_rel", BR, 6);

        // timeout on dut_b; dut_a releases normally
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 0); expect1("to_stall", MS, 16'(i));
        end
        drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);   expect2("to_enter", MS, ERR, 5, 5, 0, 1);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 1);   expect2("to_ready", NORM, ERR, 6, 6, 0, 1);
        drive(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);   expect2("to_br", BR, ERR, 6, 7, 0, 1);
        drive(1, 1, 3, 3, 0, 1, 0, 0, 0, 0);   expect2("to_lu", LU, ERR, 6, 8, 0, 1);
        do_reset();

        // long stall: dut_a times out at 16, dut_b counter saturates at 15
        for (int k = 1; k <= 22; k++) begin
            if (k <= 20) drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
            else         quiet();
            expect2("sat", (k <= 17) ? MS : ERR, (k <= 5) ? MS : ERR, 16'(k - 1),
                    (k - 1 > 15) ? 4'd15 : 4'(k - 1), k >= 18, k >= 6);
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);   expect1("sat_rst", RST, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 1);   expect1("sat_rel", NORM, 0);

        // reset while frozen in MEM_WAIT
        drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);   expect1("mid_s0", MS, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);   expect1("mid_s1", MS, 1);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);   expect1("mid_rst", RST, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 1);   expect1("mid_rel", NORM, 0);
        quiet();                               expect1("mid_quiet", NORM, 0);

        repeat (2) @(negedge clk);
        #1;
        chk("drain", "pending", 16'(sb.size()), 16'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
